// File: rtl/mem_store_align_unit.sv
// Store-path aligner: turns one store request into byte enables and lane-shifted
// write data, splitting stores that cross a bus-word boundary into two beats.
module mem_store_align_unit #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_data,
    input  logic [1:0]              req_size,
    output logic                    done_valid,
    output logic                    done_fault,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_resp
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [2*NB-1:0] size_mask(input logic [1:0] size);
        logic [15:0] m;
        case (size)
            2'd0:    m = 16'h0001;
            2'd1:    m = 16'h0003;
            2'd2:    m = 16'h000F;
            2'd3:    m = 16'h00FF;
            default: m = 16'h0000;
        endcase
        return m[2*NB-1:0];
    endfunction

    state_t                  r_state;
    logic                    r_req_ready;
    logic                    r_mem_write;
    logic [ADDR_WIDTH-1:0]   r_mem_address;
    logic [NB-1:0]           r_mem_be;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;
    logic                    r_done_valid;
    logic                    r_done_fault;
    logic [ADDR_WIDTH-1:0]   r_hi_addr;
    logic [NB-1:0]           r_hi_be;
    logic [DATA_WIDTH-1:0]   r_hi_wdata;

    logic [OFFW-1:0]         w_off;
    logic [2*NB-1:0]         w_mask2;
    logic [2*DATA_WIDTH-1:0] w_data2;
    logic [ADDR_WIDTH-1:0]   w_addr0;
    logic [ADDR_WIDTH-1:0]   w_addr1;
    logic [2:0]              w_nb_m1;
    logic                    w_fault;

    state_t                  w_nxt_state;
    logic                    w_nxt_ready;
    logic                    w_nxt_write;
    logic [ADDR_WIDTH-1:0]   w_nxt_addr;
    logic [NB-1:0]           w_nxt_be;
    logic [DATA_WIDTH-1:0]   w_nxt_wdata;
    logic                    w_nxt_dv;
    logic                    w_nxt_df;
    logic [ADDR_WIDTH-1:0]   w_nxt_hi_addr;
    logic [NB-1:0]           w_nxt_hi_be;
    logic [DATA_WIDTH-1:0]   w_nxt_hi_wdata;

    // Request decode: two-word-wide mask/data; low half is beat 0, high half beat 1.
    always_comb begin
        w_off   = req_addr[OFFW-1:0];
        w_mask2 = size_mask(req_size) << w_off;
        w_data2 = {{DATA_WIDTH{1'b0}}, req_data} << {w_off, 3'b000};
        w_addr0 = {req_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
        w_addr1 = w_addr0 + ADDR_WIDTH'(NB);
        case (req_size)
            2'd0:    w_nb_m1 = 3'd0;
            2'd1:    w_nb_m1 = 3'd1;
            2'd2:    w_nb_m1 = 3'd3;
            2'd3:    w_nb_m1 = 3'd7;
            default: w_nb_m1 = 3'd0;
        endcase
        w_fault = ((req_size == 2'd3) && (DATA_WIDTH == 32)) ||
                  ((ALLOW_MISALIGNED == 1'b0) && ((req_addr[2:0] & w_nb_m1) != 3'd0));
    end

    // Next-state and next-output logic; everything holds unless a branch changes it.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_ready    = r_req_ready;
        w_nxt_write    = r_mem_write;
        w_nxt_addr     = r_mem_address;
        w_nxt_be       = r_mem_be;
        w_nxt_wdata    = r_mem_wdata;
        w_nxt_dv       = 1'b0;
        w_nxt_df       = r_done_fault;
        w_nxt_hi_addr  = r_hi_addr;
        w_nxt_hi_be    = r_hi_be;
        w_nxt_hi_wdata = r_hi_wdata;
        case (r_state)
            S_IDLE: begin
                w_nxt_ready = 1'b1;
                w_nxt_df    = 1'b0;
                if (req_valid) begin
                    w_nxt_ready = 1'b0;
                    if (w_fault) begin
                        w_nxt_state = S_DONE;
                        w_nxt_dv    = 1'b1;
                        w_nxt_df    = 1'b1;
                    end else begin
                        w_nxt_state    = S_BEAT0;
                        w_nxt_write    = 1'b1;
                        w_nxt_addr     = w_addr0;
                        w_nxt_be       = w_mask2[NB-1:0];
                        w_nxt_wdata    = w_data2[DATA_WIDTH-1:0];
                        w_nxt_hi_addr  = w_addr1;
                        w_nxt_hi_be    = w_mask2[2*NB-1:NB];
                        w_nxt_hi_wdata = w_data2[2*DATA_WIDTH-1:DATA_WIDTH];
                    end
                end else begin
                    w_nxt_state = S_IDLE;
                end
            end
            S_BEAT0, S_BEAT1: begin
                if (mem_resp && (r_state == S_BEAT0) && (r_hi_be != {NB{1'b0}})) begin
                    // Second beat follows back-to-back; mem_write never drops.
                    w_nxt_state = S_BEAT1;
                    w_nxt_addr  = r_hi_addr;
                    w_nxt_be    = r_hi_be;
                    w_nxt_wdata = r_hi_wdata;
                end else if (mem_resp) begin
                    w_nxt_state = S_DONE;
                    w_nxt_write = 1'b0;
                    w_nxt_addr  = {ADDR_WIDTH{1'b0}};
                    w_nxt_be    = {NB{1'b0}};
                    w_nxt_wdata = {DATA_WIDTH{1'b0}};
                    w_nxt_dv    = 1'b1;
                    w_nxt_df    = 1'b0;
                end else begin
                    w_nxt_state = r_state;
                end
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
                w_nxt_ready = 1'b1;
                w_nxt_df    = 1'b0;
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_ready = 1'b1;
                w_nxt_write = 1'b0;
                w_nxt_be    = {NB{1'b0}};
                w_nxt_df    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b1;
            r_mem_write   <= 1'b0;
            r_mem_address <= {ADDR_WIDTH{1'b0}};
            r_mem_be      <= {NB{1'b0}};
            r_mem_wdata   <= {DATA_WIDTH{1'b0}};
            r_done_valid  <= 1'b0;
            r_done_fault  <= 1'b0;
            r_hi_addr     <= {ADDR_WIDTH{1'b0}};
            r_hi_be       <= {NB{1'b0}};
            r_hi_wdata    <= {DATA_WIDTH{1'b0}};
        end else begin
            r_state       <= w_nxt_state;
            r_req_ready   <= w_nxt_ready;
            r_mem_write   <= w_nxt_write;
            r_mem_address <= w_nxt_addr;
            r_mem_be      <= w_nxt_be;
            r_mem_wdata   <= w_nxt_wdata;
            r_done_valid  <= w_nxt_dv;
            r_done_fault  <= w_nxt_df;
            r_hi_addr     <= w_nxt_hi_addr;
            r_hi_be       <= w_nxt_hi_be;
            r_hi_wdata    <= w_nxt_hi_wdata;
        end
    end

    assign req_ready       = r_req_ready;
    assign mem_write       = r_mem_write;
    assign mem_address     = r_mem_address;
    assign mem_byte_enable = r_mem_be;
    assign mem_wdata       = r_mem_wdata;
    assign done_valid      = r_done_valid;
    assign done_fault      = r_done_fault;

endmodule
